// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the non-restoring divider slice.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nonrestoring_divider_controller.sv
// Divider sequencing FSM: iteration counter, busy/done flags and datapath strobes.
module divider_controller
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic divisor_zero,
  input  logic a_sign,
  output logic busy,
  output logic done,
  output logic ld_c,
  output logic ld_zero_c,
  output logic sft_addsub_c,
  output logic fix_c,
  output logic fix_add_c,
  output logic ld_out_c
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(1));
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ld_c         = 1'b0;
    ld_zero_c    = 1'b0;
    sft_addsub_c = 1'b0;
    fix_c        = 1'b0;
    fix_add_c    = 1'b0;
    ld_out_c     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (divisor_zero) begin
            ld_zero_c = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            ld_c    = 1'b1;
            cnt_d   = CNT_W'(WIDTH);
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        sft_addsub_c = 1'b1;
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        // Negative partial remainder needs one restoring add before publishing.
        fix_c     = 1'b1;
        fix_add_c = a_sign;
        ld_out_c  = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential non-restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned AW = WIDTH + 1;

  logic [AW-1:0]    a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic ld_c, ld_zero_c, sft_addsub_c, fix_c, fix_add_c, ld_out_c;
  logic busy_ctl, done_ctl;

  logic [AW-1:0]    a_sh, a_step, a_fix;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_res, r_res;

  divider_controller #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .divisor_zero (divisor == '0),
    .a_sign       (a_q[AW-1]),
    .busy         (busy_ctl),
    .done         (done_ctl),
    .ld_c         (ld_c),
    .ld_zero_c    (ld_zero_c),
    .sft_addsub_c (sft_addsub_c),
    .fix_c        (fix_c),
    .fix_add_c    (fix_add_c),
    .ld_out_c     (ld_out_c)
  );

  assign busy        = busy_ctl;
  assign done        = done_ctl;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  // Shift {A,Q} and add or subtract M depending on the current sign of A.
  always_comb begin
    a_sh   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_step = a_q[AW-1] ? (a_sh + {1'b0, m_q}) : (a_sh - {1'b0, m_q});
    a_fix  = fix_add_c ? (a_q + {1'b0, m_q}) : a_q;
  end

`ifdef DIV_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  // Magnitudes feed the unsigned core; most-negative maps to itself, which is correct unsigned.
  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (ld_c) begin
      q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_d = dividend[WIDTH-1];
    end
    q_res = q_neg_q ? WIDTH'(-q_q) : q_q;
    r_res = r_neg_q ? WIDTH'(-a_fix[WIDTH-1:0]) : a_fix[WIDTH-1:0];
  end
`else
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    q_res   = q_q;
    r_res   = a_fix[WIDTH-1:0];
  end
`endif

  always_comb begin
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    if (ld_c) begin
      a_d = '0;
      q_d = dvd_mag;
      m_d = dvs_mag;
    end
    if (sft_addsub_c) begin
      a_d = a_step;
      q_d = {q_q[WIDTH-2:0], ~a_step[AW-1]};
    end
    if (fix_c) a_d = a_fix;
    if (ld_out_c) begin
      quotient_d  = q_res;
      remainder_d = r_res;
      dbz_d       = 1'b0;
    end
    if (ld_zero_c) begin
      quotient_d  = '1;
      remainder_d = dividend;
      dbz_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider against an arithmetic reference model.
module tb_nonrestoring_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  nonrestoring_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output int lat);
    int sa, sb;
    sa = 0;
    sb = 0;
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; dz = 1'b1; lat = 1;
    end else begin
      dz = 1'b0; lat = 18;
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      if (a == 16'h8000 && b == 16'hFFFF) begin
        q = 16'h8000; r = 16'h0000;
      end else begin
        q = 16'(sa / sb);
        r = 16'(sa % sb);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Issue one operation; lat counts cycles from the accepting edge to done visible.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                       output logic [15:0] q, output logic [15:0] r, output logic dz,
                       output logic got_done, output logic overlap, output logic busy_seen);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; overlap = 1'b0; busy_seen = busy;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_seen = 1'b1;
    end
    got_done = done;
    overlap  = done && busy;
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] a_t[3] = '{16'd100, 16'hFFFF, 16'h0003};
    logic [15:0] b_t[3] = '{16'd7,   16'h0001, 16'h0010};
    int lat, elat;
    logic [15:0] q, r, eq, er;
    logic dz, edz, gd, ov, bs;
    for (int i = 0; i < 3; i++) begin
      model(a_t[i], b_t[i], eq, er, edz, elat);
      do_op(a_t[i], b_t[i], lat, q, r, dz, gd, ov, bs);
      checks++;
      if (!gd || lat != elat) begin
        failures++;
        $display("FAIL directed_latency %h/%h got %0d (done=%b) expected %0d", a_t[i], b_t[i], lat, gd, elat);
      end
      checks++;
      if (q !== eq || r !== er || dz !== edz) begin
        failures++;
        $display("FAIL directed_result %h/%h got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                 a_t[i], b_t[i], q, r, dz, eq, er, edz);
      end
      checks++;
      if (ov) begin
        failures++;
        $display("FAIL directed_busy_done_overlap got busy=1 with done expected busy=0");
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [15:0] q, r;
    logic dz, gd, ov, bs;
    do_op(16'd5, 16'd0, lat, q, r, dz, gd, ov, bs);
    checks++;
    if (!gd || lat != 1 || bs) begin
      failures++;
      $display("FAIL div_zero_timing got lat=%0d done=%b busy_seen=%b expected lat=1 done=1 busy_seen=0", lat, gd, bs);
    end
    checks++;
    if (q !== 16'hFFFF || r !== 16'd5 || dz !== 1'b1) begin
      failures++;
      $display("FAIL div_zero_result got q=%h r=%h dz=%b expected q=ffff r=0005 dz=1", q, r, dz);
    end
  endtask

  // Done is a single pulse and results hold afterwards.
  task automatic test_hold();
    int lat, dones;
    logic [15:0] q, r;
    logic dz, gd, ov, bs, changed;
    do_op(16'd1000, 16'd33, lat, q, r, dz, gd, ov, bs);
    dones = 0; changed = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (quotient !== 16'd30 || remainder !== 16'd10 || div_by_zero !== 1'b0) changed = 1'b1;
    end
    checks++;
    if (dones != 0 || changed) begin
      failures++;
      $display("FAIL hold_after_done got extra_dones=%0d changed=%b q=%h r=%h expected 0 0 q=001e r=000a",
               dones, changed, quotient, remainder);
    end
  endtask

  task automatic test_busy_ignore();
    int dones, first_lat, cyc;
    logic [15:0] q, r;
    @(negedge clk); start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1; dones = 0; first_lat = 0; q = '0; r = '0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    @(negedge clk); start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(posedge clk); #1; start = 1'b0; cyc++;
    while (cyc < 30) begin
      if (done) begin
        dones++;
        if (first_lat == 0) begin first_lat = cyc; q = quotient; r = remainder; end
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (dones != 1 || first_lat != 18) begin
      failures++;
      $display("FAIL busy_ignore_done got dones=%0d lat=%0d expected dones=1 lat=18", dones, first_lat);
    end
    checks++;
    if (q !== 16'd3 || r !== 16'd0) begin
      failures++;
      $display("FAIL busy_ignore_result got q=%h r=%h expected q=0003 r=0000", q, r);
    end
  endtask

  task automatic test_reset_mid();
    int lat, dones;
    logic [15:0] q, r;
    logic dz, gd, ov, bs;
    @(negedge clk); start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear got busy=%b done=%b q=%h r=%h dbz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (25) begin @(posedge clk); #1; if (done || busy) dones++; end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet got active_cycles=%0d expected 0", dones);
    end
    do_op(16'd9, 16'd3, lat, q, r, dz, gd, ov, bs);
    checks++;
    if (!gd || lat != 18 || q !== 16'd3 || r !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_recover got done=%b lat=%0d q=%h r=%h expected 1 18 0003 0000", gd, lat, q, r);
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [15:0] a, b, q, r, eq, er;
    logic dz, edz, gd, ov, bs;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      case ($urandom_range(3))
        0: b = 16'($urandom_range(15));
        1: b = 16'($urandom_range(255));
        default: b = 16'($urandom);
      endcase
      model(a, b, eq, er, edz, elat);
      do_op(a, b, lat, q, r, dz, gd, ov, bs);
      checks++;
      if (!gd || lat != elat || ov || q !== eq || r !== er || dz !== edz) begin
        failures++;
        $display("FAIL random_op %h/%h got done=%b lat=%0d ov=%b q=%h r=%h dz=%b expected 1 %0d 0 q=%h r=%h dz=%b",
                 a, b, gd, lat, ov, q, r, dz, elat, eq, er, edz);
      end
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [15:0] a_t[3] = '{16'hFFF9, 16'h0007, 16'h8000};
    logic [15:0] b_t[3] = '{16'h0002, 16'hFFFE, 16'hFFFF};
    logic [15:0] q_t[3] = '{16'hFFFD, 16'hFFFD, 16'h8000};
    logic [15:0] r_t[3] = '{16'hFFFF, 16'h0001, 16'h0000};
    int lat;
    logic [15:0] q, r;
    logic dz, gd, ov, bs;
    for (int i = 0; i < 3; i++) begin
      do_op(a_t[i], b_t[i], lat, q, r, dz, gd, ov, bs);
      checks++;
      if (!gd || q !== q_t[i] || r !== r_t[i] || dz !== 1'b0) begin
        failures++;
        $display("FAIL signed_directed %h/%h got done=%b q=%h r=%h dz=%b expected q=%h r=%h dz=0",
                 a_t[i], b_t[i], gd, q, r, dz, q_t[i], r_t[i]);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_hold();
    test_busy_ignore();
    test_reset_mid();
    test_random();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
